// File: rtl/efuse_pkg.sv
// =============================================================================
// Module      : efuse_pkg
// Description : Shared types, sizes and trim-field offsets for the eFuse block
// Revision    : 1.0
// =============================================================================
`default_nettype none

package efuse_pkg;

    localparam int EFUSE_BITS = 32;
    localparam int BIT_IDX_W  = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        SCLK_H = 3'd2,
        SCLK_L = 3'd3,
        HOLD   = 3'd4,
        DONE   = 3'd5
    } efuse_state_e;

    // Trim field layout inside efuse_rdata, consumed by the register file
    localparam int TRIM_CP_LSB   = 0;
    localparam int TRIM_CP_W     = 4;
    localparam int TRIM_DIV_LSB  = 4;
    localparam int TRIM_DIV_W    = 8;
    localparam int TRIM_VBG_LSB  = 12;
    localparam int TRIM_VBG_W    = 6;
    localparam int TRIM_V2I_LSB  = 18;
    localparam int TRIM_V2I_W    = 6;
    localparam int TRIM_LDO_LSB  = 24;
    localparam int TRIM_LDO_W    = 3;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/efuse_phase_timer.sv
// =============================================================================
// Module      : efuse_phase_timer
// Description : Loadable down-counter with zero flag timing each FSM phase
// Revision    : 1.0
// =============================================================================
`default_nettype none

module efuse_phase_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_osc,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_osc or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/efuse_ctrl.sv
// =============================================================================
// Module      : efuse_ctrl
// Description : Read/program sequencer for the 32-bit serial eFuse macro
// Revision    : 1.0
// =============================================================================
`default_nettype none

module efuse_ctrl
    import efuse_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int SCLK_HALF = 4,
    parameter int PGM_CYC   = 200,
    parameter int HOLD_CYC  = 2,
    parameter bit AUTO_LOAD = 1'b1
) (
    input  logic        clk_osc,
    input  logic        rst_n,
    input  logic        efuse_rd_req,
    input  logic        efuse_wr_req,
    input  logic        efuse_wr_en,
    input  logic [31:0] efuse_wdata,
    output logic [31:0] efuse_rdata,
    output logic        efuse_valid,
    output logic        efuse_busy,
    output logic        efuse_done,
    output logic        EFUSE_CS,
    output logic        EFUSE_RW,
    output logic        EFUSE_PGM,
    output logic        EFUSE_SCLK,
    input  logic        EFUSE_DOUT
);

    localparam int TMR_MAX = max4(PGM_CYC, SCLK_HALF, SETUP_CYC, HOLD_CYC);
    localparam int TW      = $clog2(TMR_MAX + 1);

    localparam logic [TW-1:0] SETUP_VAL = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] HALF_VAL  = TW'(SCLK_HALF - 1);
    localparam logic [TW-1:0] PGM_VAL   = TW'(PGM_CYC - 1);
    localparam logic [TW-1:0] HOLD_VAL  = TW'(HOLD_CYC - 1);

    efuse_state_e          state_q, state_d;
    logic                  rw_q, rw_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [BIT_IDX_W-1:0]  bit_q, bit_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  valid_q, valid_d;
    logic                  auto_q;
    logic                  cs_q, rwo_q, pgm_q, sclk_q, busy_q, done_q;

    logic                  tmr_load;
    logic [TW-1:0]         tmr_val;
    logic                  tmr_zero;
    logic [BIT_IDX_W-1:0]  bit_inc;
    logic                  cs_d;

    efuse_phase_timer #(.WIDTH(TW)) u_timer (
        .clk_osc    (clk_osc),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    assign bit_inc = bit_q + 5'd1;

    always_comb begin
        state_d  = state_q;
        rw_d     = rw_q;
        wdata_d  = wdata_q;
        bit_d    = bit_q;
        rdata_d  = rdata_q;
        valid_d  = valid_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            IDLE: begin
                // Read wins over a simultaneous program request
                if (efuse_rd_req || auto_q) begin
                    state_d  = SETUP;
                    rw_d     = 1'b0;
                    valid_d  = 1'b0;
                    bit_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_VAL;
                end else if (efuse_wr_req && efuse_wr_en) begin
                    state_d  = SETUP;
                    rw_d     = 1'b1;
                    wdata_d  = efuse_wdata;
                    bit_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_VAL;
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    state_d  = SCLK_H;
                    tmr_load = 1'b1;
                    tmr_val  = (rw_q && wdata_q[bit_q]) ? PGM_VAL : HALF_VAL;
                end
            end
            SCLK_H: begin
                if (tmr_zero) begin
                    if (!rw_q) rdata_d[bit_q] = EFUSE_DOUT;
                    state_d  = SCLK_L;
                    tmr_load = 1'b1;
                    tmr_val  = HALF_VAL;
                end
            end
            SCLK_L: begin
                if (tmr_zero) begin
                    bit_d    = bit_inc;
                    tmr_load = 1'b1;
                    if (bit_q == 5'd31) begin
                        state_d = HOLD;
                        tmr_val = HOLD_VAL;
                    end else begin
                        state_d = SCLK_H;
                        tmr_val = (rw_q && wdata_q[bit_inc]) ? PGM_VAL : HALF_VAL;
                    end
                end
            end
            HOLD: begin
                if (tmr_zero) begin
                    state_d = DONE;
                    // A program leaves the shadow stale until a re-read
                    valid_d = !rw_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cs_d = (state_d == SETUP) || (state_d == SCLK_H) ||
                  (state_d == SCLK_L) || (state_d == HOLD);

    // Pad outputs are registered from next-state so they align with the FSM
    always_ff @(posedge clk_osc or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            bit_q   <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            auto_q  <= AUTO_LOAD;
            cs_q    <= 1'b0;
            rwo_q   <= 1'b0;
            pgm_q   <= 1'b0;
            sclk_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            bit_q   <= bit_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            auto_q  <= 1'b0;
            cs_q    <= cs_d;
            rwo_q   <= cs_d && rw_d;
            pgm_q   <= (state_d == SCLK_H) && rw_d && wdata_d[bit_d];
            sclk_q  <= (state_d == SCLK_H);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign efuse_rdata = rdata_q;
    assign efuse_valid = valid_q;
    assign efuse_busy  = busy_q;
    assign efuse_done  = done_q;
    assign EFUSE_CS    = cs_q;
    assign EFUSE_RW    = rwo_q;
    assign EFUSE_PGM   = pgm_q;
    assign EFUSE_SCLK  = sclk_q;

endmodule

`default_nettype wire
